negpulse_generator: RTL and testbench
=====================================

// Module: negpulse_generator
// PURPOSE
//  Transmit-side counterpart to the edge detectors. It converts a one-cycle trigger
//  strobe into a train of active-low pulses with programmable delay, width, gap and
//  count. Each pulse presents exactly one negative edge to downstream logic on the
//  same clock, or to logic across an FPGA pin.
//  Used to fire test strobes and external trigger lines from the slow-control register file.
// PARAMETERS
//  CNT_W  16  width of the delay/width/gap counters and settings
//  NP_W    8  width of the pulse-count setting
// PORTS
//  clk       in   1      system clock; all logic on posedge
//  rst_n     in   1      reset, asynchronous, active-low
//  trig      in   1      start strobe; sampled every posedge
//  delay     in   CNT_W  cycles from trig to first falling edge; 0 allowed
//  width     in   CNT_W  low time per pulse in cycles; 0 treated as 1
//  gap       in   CNT_W  high time between pulses in cycles; 0 treated as 1
//  npulses   in   NP_W   pulses per trigger; 0 treated as 1
//  y         out  1      pulse output; idle high, registered
//  busy      out  1      high from the trig-sampling edge until the final rising edge of y
//  done      out  1      one-cycle strobe coinciding with the final rising edge of y
//  trig_drop out  1      one-cycle strobe: trig sampled while busy and ignored
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, y=1, busy=0, done=0, trig_drop=0,
//   all counters cleared. Asserting reset mid-train aborts it immediately. y returns
//   high even if the train was mid-pulse, and no done is generated.
//  Settings: delay/width/gap/npulses are latched on the edge that accepts trig.
//   Changes to these inputs while busy have no effect.
//  FSM states: IDLE, DELAY, LOW, GAP. All outputs are registered and change only on posedge.
//   IDLE : when trig=1, latch settings and set busy=1.
//          If delay==0, go to LOW and set y=0 on this same edge.
//          Otherwise go to DELAY with cnt=delay-1.
//   DELAY: decrement cnt. At the edge where cnt==0, go to LOW and set y=0.
//   LOW  : y stays low for exactly max(width,1) cycles.
//          At the end of that time, set y=1 and decrement the remaining-pulse count.
//          If no pulses remain: go to IDLE, set busy=0, and set done=1 for one cycle.
//          Otherwise go to GAP.
//   GAP  : y stays high for exactly max(gap,1) cycles, then go to LOW and set y=0.
//  Timing: with trig sampled at edge E0, d=delay, w=max(width,1), g=max(gap,1),
//   n=max(npulses,1):
//   - pulse k (k=0..n-1) falls at edge E0+d+k*(w+g) and rises at edge E0+d+k*(w+g)+w;
//   - busy falls, and done is high, starting at the last rise edge;
//   - a new trig is accepted no earlier than the edge after busy falls.
//  Counters are CNT_W bits unsigned. The maximum delay is 2^CNT_W-1 with no wrap.
//  The pulse count is NP_W bits.
//  Simultaneous events:
//   - trig=1 on the same edge that busy falls: ignored, and trig_drop=1.
//   - trig held high for several cycles: exactly one train starts; every further
//     sampled high while busy gives a trig_drop strobe.
//   - trig=1 in IDLE: starts a train even if trig was also high on the previous cycle.
//  Invariant: y is never low in IDLE or DELAY. Between two pulses, y is high for at least one cycle.
// TESTING
//  1. delay=0,width=1,gap=0,npulses=0, one trig -> y low exactly 1 cycle after the
//     trig edge; done pulses when y rises; busy high for 1 cycle.
//  2. delay=3,width=4,gap=2,npulses=3 -> falls at E0+3,+9,+15; each low 4 cycles;
//     done at E0+19; a negedge_detector on y fires exactly 3 times.
//  3. Start the case-2 train, pulse trig at E0+5 and change width to 9 at E0+6 ->
//     trig_drop=1 once; timing identical to case 2.
//  4. Assert rst_n=0 asynchronously mid-LOW in case 2 -> y=1 and busy=0 without waiting
//     for a clock; no done; after release a trig works normally.
//  5. Back-to-back: trig on the edge busy falls (dropped), then trig one cycle later
//     -> second train starts; y high for at least 1 cycle between trains.
//  6. delay=2^CNT_W-1,width=1 -> first fall at E0+65535 (CNT_W=16); no counter wrap.

Source files
------------

// File: rtl/negpulse_generator_if.sv
// negpulse_generator_if: trigger/settings and pulse-train status bundle for negpulse_generator
interface negpulse_generator_if #(
  parameter int CNT_W = 16,
  parameter int NP_W  = 8
);
  logic             trig;
  logic [CNT_W-1:0] delay;
  logic [CNT_W-1:0] width;
  logic [CNT_W-1:0] gap;
  logic [NP_W-1:0]  npulses;
  logic             y;
  logic             busy;
  logic             done;
  logic             trig_drop;
  modport master (
    output trig, delay, width, gap, npulses,
    input  y, busy, done, trig_drop
  );
  modport slave (
    input  trig, delay, width, gap, npulses,
    output y, busy, done, trig_drop
  );
endinterface

// File: rtl/negpulse_generator.sv
// negpulse_generator: turns a trig strobe into a train of active-low pulses
// with programmable delay, width, gap and count; all outputs registered.
module negpulse_generator #(
  parameter int CNT_W = 16,
  parameter int NP_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  negpulse_generator_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DELAY, LOW, GAP} state_t;
  state_t           r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [CNT_W-1:0] r_wm1, w_wm1;
  logic [CNT_W-1:0] r_gm1, w_gm1;
  logic [NP_W-1:0]  r_rem, w_rem;
  logic             r_y, w_y;
  logic             r_busy, w_busy;
  logic             r_done, w_done;
  logic             r_drop, w_drop;
  logic [CNT_W-1:0] w_in_wm1, w_in_gm1;
  logic [NP_W-1:0]  w_in_nm1;
  logic             w_cnt_zero;
  // settings are held as (value-1) with 0 clamped to 1, so a zero count marks the last cycle
  assign w_in_wm1   = (bus.width == '0) ? '0 : bus.width - CNT_W'(1);
  assign w_in_gm1   = (bus.gap == '0) ? '0 : bus.gap - CNT_W'(1);
  assign w_in_nm1   = (bus.npulses == '0) ? '0 : bus.npulses - NP_W'(1);
  assign w_cnt_zero = (r_cnt == '0);
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_wm1   = r_wm1;
    w_gm1   = r_gm1;
    w_rem   = r_rem;
    w_y     = r_y;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_drop  = bus.trig && (r_state != IDLE);
    case (r_state)
      IDLE: if (bus.trig) begin
        w_busy  = 1'b1;
        w_wm1   = w_in_wm1;
        w_gm1   = w_in_gm1;
        w_rem   = w_in_nm1;
        w_state = (bus.delay == '0) ? LOW : DELAY;
        w_y     = (bus.delay != '0);
        w_cnt   = (bus.delay == '0) ? w_in_wm1 : bus.delay - CNT_W'(1);
      end
      DELAY: begin
        w_state = w_cnt_zero ? LOW : DELAY;
        w_y     = !w_cnt_zero;
        w_cnt   = w_cnt_zero ? r_wm1 : r_cnt - CNT_W'(1);
      end
      LOW: if (w_cnt_zero) begin
        w_y     = 1'b1;
        w_state = (r_rem == '0) ? IDLE : GAP;
        w_busy  = (r_rem != '0);
        w_done  = (r_rem == '0);
        w_rem   = (r_rem == '0) ? r_rem : r_rem - NP_W'(1);
        w_cnt   = r_gm1;
      end else begin
        w_cnt = r_cnt - CNT_W'(1);
      end
      GAP: begin
        w_state = w_cnt_zero ? LOW : GAP;
        w_y     = !w_cnt_zero;
        w_cnt   = w_cnt_zero ? r_wm1 : r_cnt - CNT_W'(1);
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_wm1   <= '0;
      r_gm1   <= '0;
      r_rem   <= '0;
      r_y     <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_wm1   <= w_wm1;
      r_gm1   <= w_gm1;
      r_rem   <= w_rem;
      r_y     <= w_y;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_drop  <= w_drop;
    end
  end
  assign bus.y         = r_y;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.trig_drop = r_drop;
endmodule

// File: tb/tb_negpulse_generator.sv
// tb_negpulse_generator: table-driven pulse-train checks plus reset and back-to-back sequences
module tb_negpulse_generator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  negpulse_generator_if #(.CNT_W(16), .NP_W(8)) bus ();
  negpulse_generator #(.CNT_W(16), .NP_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    int delay, width, gap, np, drop_at;
    int e_fall, e_falls, e_done, e_low, e_drops;
  } vec_t;
  vec_t vecs[8];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic run_vec(input int idx, input vec_t v);
    int falls = 0, first = -1, done_at = -1, lows = 0, drops = 0, busys = 0;
    logic py = 1'b1;
    @(negedge clk);
    bus.delay   = 16'(v.delay);
    bus.width   = 16'(v.width);
    bus.gap     = 16'(v.gap);
    bus.npulses = 8'(v.np);
    bus.trig    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.trig = 1'b0;
    for (int k = 0; k < 70000 && done_at < 0; k++) begin
      if (k > 0) @(negedge clk);
      if (!bus.y && py) begin
        falls++;
        if (first < 0) first = k;
      end
      py = bus.y;
      lows  += int'(!bus.y);
      drops += int'(bus.trig_drop);
      busys += int'(bus.busy);
      if (bus.done) done_at = k;
      bus.trig = (k == v.drop_at - 1);
      if (k == v.drop_at) bus.width = 16'd9;
    end
    bus.trig = 1'b0;
    chk($sformatf("v%0d first_fall", idx), first, v.e_fall);
    chk($sformatf("v%0d falls", idx), falls, v.e_falls);
    chk($sformatf("v%0d done_at", idx), done_at, v.e_done);
    chk($sformatf("v%0d low_cycles", idx), lows, v.e_low);
    chk($sformatf("v%0d busy_cycles", idx), busys, v.e_done);
    chk($sformatf("v%0d drops", idx), drops, v.e_drops);
  endtask
  initial begin
    int dn, lw;
    vecs[0] = '{0, 1, 0, 0, -1, 0, 1, 1, 1, 0};
    vecs[1] = '{3, 4, 2, 3, -1, 3, 3, 19, 12, 0};
    vecs[2] = '{3, 4, 2, 3, 5, 3, 3, 19, 12, 1};
    vecs[3] = '{5, 0, 0, 2, -1, 5, 2, 8, 2, 0};
    vecs[4] = '{1, 2, 3, 1, -1, 1, 1, 3, 2, 0};
    vecs[5] = '{0, 3, 1, 4, -1, 0, 4, 15, 12, 0};
    vecs[6] = '{2, 1, 1, 5, -1, 2, 5, 11, 5, 0};
    vecs[7] = '{65535, 1, 0, 1, -1, 65535, 1, 65536, 1, 0};
    bus.trig = 1'b0;
    bus.delay = '0;
    bus.width = '0;
    bus.gap = '0;
    bus.npulses = '0;
    repeat (2) @(negedge clk);
    chk("rst y", int'(bus.y), 1);
    chk("rst busy", int'(bus.busy), 0);
    chk("rst done", int'(bus.done), 0);
    chk("rst trig_drop", int'(bus.trig_drop), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);
    // asynchronous reset in the middle of a low pulse
    @(negedge clk);
    bus.delay = 16'd3;
    bus.width = 16'd4;
    bus.gap = 16'd2;
    bus.npulses = 8'd3;
    bus.trig = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.trig = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort pre y", int'(bus.y), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort y", int'(bus.y), 1);
    chk("abort busy", int'(bus.busy), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    lw = 0;
    repeat (25) begin
      @(negedge clk);
      dn += int'(bus.done);
      lw += int'(!bus.y);
    end
    chk("abort no_done", dn, 0);
    chk("abort y_idle_low", lw, 0);
    run_vec(8, vecs[0]);
    // trig held across the busy-falling edge, then accepted one cycle later
    @(negedge clk);
    bus.delay = 16'd0;
    bus.width = 16'd1;
    bus.gap = 16'd0;
    bus.npulses = 8'd1;
    bus.trig = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("b2b s0 y", int'(bus.y), 0);
    @(negedge clk);
    chk("b2b s1 y", int'(bus.y), 1);
    chk("b2b s1 done", int'(bus.done), 1);
    chk("b2b s1 busy", int'(bus.busy), 0);
    chk("b2b s1 drop", int'(bus.trig_drop), 1);
    @(negedge clk);
    bus.trig = 1'b0;
    chk("b2b s2 y", int'(bus.y), 0);
    chk("b2b s2 busy", int'(bus.busy), 1);
    chk("b2b s2 drop", int'(bus.trig_drop), 0);
    @(negedge clk);
    chk("b2b s3 y", int'(bus.y), 1);
    chk("b2b s3 done", int'(bus.done), 1);
    @(negedge clk);
    chk("b2b s4 done", int'(bus.done), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
